hazard_ctrl: RTL and testbench
==============================

HAZARD_CTRL -- requirements
Module: hazard_ctrl

Interface
REQ-001 Parameter REG_W, default 5, SHALL set the register-address width.
REQ-002 Parameter LOAD_LAT, default 1, legal range 1..4, SHALL set the number of cycles a load occupies the MEM stage.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 RsD, RtD  in  REG_W  SHALL be the decode-stage source registers.
REQ-006 BranchD  in  1  SHALL flag a branch in decode.
REQ-007 syscallD  in  1  SHALL flag a syscall in decode.
REQ-008 RsE, RtE  in  REG_W  SHALL be the execute-stage source registers.
REQ-009 WriteRegE, MemtoRegE, RegWriteE  in  REG_W/1/1  SHALL be the execute-stage destination, load flag and write-enable.
REQ-010 WriteRegM, MemtoRegM, RegWriteM  in  REG_W/1/1  SHALL be the memory-stage destination, load flag and write-enable.
REQ-011 WriteRegW, RegWriteW  in  REG_W/1  SHALL be the writeback-stage destination and write-enable.
REQ-012 StallF, StallD  out  1  SHALL hold the PC and IF/ID registers.
REQ-013 StallEM  out  1  SHALL hold the ID/EX and EX/MEM registers.
REQ-014 FlushE  out  1  SHALL insert a bubble into ID/EX.
REQ-015 ForwardAE, ForwardBE  out  2  SHALL select the execute-stage operand source (00 regfile, 01 W, 10 M).
REQ-016 ForwardAD, ForwardBD  out  1  SHALL select M-stage forwarding into the decode branch comparator.
REQ-017 syscall_go  out  1  SHALL be a one-cycle pulse releasing the syscall handler.
REQ-018 stall_count  out  16  SHALL count cycles with StallF high.

Function
REQ-019 ForwardAE SHALL be 10 when RsE!=0, RsE==WriteRegM and RegWriteM are all true; else 01 when RsE!=0, RsE==WriteRegW and RegWriteW; else 00; ForwardBE identically on RtE; M has priority.
REQ-020 lwStall SHALL be MemtoRegE & WriteRegE!=0 & (WriteRegE==RsD | WriteRegE==RtD).
REQ-021 branchStall SHALL be BranchD & ((RegWriteE & WriteRegE!=0 & WriteRegE matches RsD or RtD) | (MemtoRegM & WriteRegM!=0 & WriteRegM matches RsD or RtD)).
REQ-022 A 2-bit counter mcnt SHALL create memStall = MemtoRegM & (mcnt != LOAD_LAT-1); mcnt increments while memStall is high and returns to 0 otherwise, so each load holds M for exactly LOAD_LAT cycles; LOAD_LAT=1 gives memStall always 0.
REQ-023 While memStall is high, StallF, StallD and StallEM SHALL be 1 and FlushE SHALL be 0; memStall overrides all flushes.
REQ-024 Otherwise StallF = StallD = FlushE = lwStall | branchStall | (syscall FSM in DRAIN or FIRE).
REQ-025 Syscall FSM states SHALL be IDLE, DRAIN, FIRE and PASS.
REQ-026 Syscall FSM transitions SHALL be: IDLE->DRAIN on syscallD & !lwStall & !branchStall & !memStall; DRAIN->FIRE when RegWriteE, RegWriteM and RegWriteW are all 0; FIRE->PASS unconditionally, with syscall_go=1; PASS->IDLE unconditionally, with syscallD ignored and the syscall advancing.
REQ-027 stall_count SHALL increment every cycle StallF=1 and saturate at 16'hFFFF.
REQ-028 Stall outputs, FlushE and syscall_go SHALL be combinational from the current inputs and state, with zero-cycle latency.

Reset
REQ-029 While rst=1, the FSM SHALL go to IDLE and mcnt and stall_count SHALL go to 0; StallF, StallD, StallEM, FlushE and syscall_go SHALL be 0; forwarding outputs SHALL remain combinational; a reset mid-DRAIN or mid-load SHALL abandon the operation.

Configuration
REQ-030 With HAZARD_BRANCH_FWD_EN defined, ForwardAD SHALL be (RsD!=0 & RsD==WriteRegM & RegWriteM), ForwardBD SHALL be the same on RtD, and branchStall SHALL be as in REQ-021.
REQ-031 Without HAZARD_BRANCH_FWD_EN, ForwardAD and ForwardBD SHALL be tied 0, and branchStall SHALL additionally include BranchD & RegWriteM & WriteRegM!=0 & WriteRegM matches RsD or RtD.

Verification
REQ-032 RsE=3, WriteRegM=3, RegWriteM=1, WriteRegW=3, RegWriteW=1 -> ForwardAE=10; with RsE=0 instead -> ForwardAE=00.
REQ-033 MemtoRegE=1, WriteRegE=5, RtD=5 -> StallF=StallD=FlushE=1 for one cycle; with WriteRegE=0 -> no stall.
REQ-034 LOAD_LAT=3 and MemtoRegM held -> StallEM=1 for 2 cycles and 0 on the 3rd; mcnt sequence 0,1,2,0; FlushE=0 throughout.
REQ-035 syscallD=1 with RegWriteM=1 for 2 cycles -> DRAIN for 2 cycles, then syscall_go=1 for exactly 1 cycle, then PASS with no stall, then IDLE.
REQ-036 BranchD=1, RegWriteM=1, WriteRegM=RsD=7 -> with the macro, ForwardAD=1 and no stall; without the macro, StallF=1 and ForwardAD=0; rst asserted mid-DRAIN -> IDLE and stall_count=0 on the next cycle.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Pipeline hazard unit: operand forwarding, load/branch stalls, multi-cycle MEM loads, syscall drain.
// Define HAZARD_BRANCH_FWD_EN to forward the M stage into the decode branch comparator.
module hazard_ctrl #(
    parameter int REG_W    = 5,
    parameter int LOAD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [REG_W-1:0] RsD,
    input  logic [REG_W-1:0] RtD,
    input  logic             BranchD,
    input  logic             syscallD,
    input  logic [REG_W-1:0] RsE,
    input  logic [REG_W-1:0] RtE,
    input  logic [REG_W-1:0] WriteRegE,
    input  logic             MemtoRegE,
    input  logic             RegWriteE,
    input  logic [REG_W-1:0] WriteRegM,
    input  logic             MemtoRegM,
    input  logic             RegWriteM,
    input  logic [REG_W-1:0] WriteRegW,
    input  logic             RegWriteW,
    output logic             StallF,
    output logic             StallD,
    output logic             StallEM,
    output logic             FlushE,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic             ForwardAD,
    output logic             ForwardBD,
    output logic             syscall_go,
    output logic [15:0]      stall_count
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        FIRE  = 2'd2,
        PASS  = 2'd3
    } sys_state_t;

    localparam logic [1:0] MCNT_LAST = 2'(LOAD_LAT - 1);

    sys_state_t  state_q, state_d;
    logic [1:0]  mcnt_q, mcnt_d;
    logic [15:0] stall_count_q, stall_count_d;

    logic lw_stall;
    logic branch_stall;
    logic mem_stall;
    logic e_hits_d;
    logic m_hits_d;
    logic sys_stall;

    always_comb begin
        ForwardAE = 2'b00;
        ForwardBE = 2'b00;
        if (RsE != '0 && RsE == WriteRegM && RegWriteM)
            ForwardAE = 2'b10;
        else if (RsE != '0 && RsE == WriteRegW && RegWriteW)
            ForwardAE = 2'b01;
        if (RtE != '0 && RtE == WriteRegM && RegWriteM)
            ForwardBE = 2'b10;
        else if (RtE != '0 && RtE == WriteRegW && RegWriteW)
            ForwardBE = 2'b01;
    end

    assign e_hits_d = (WriteRegE != '0) && (WriteRegE == RsD || WriteRegE == RtD);
    assign m_hits_d = (WriteRegM != '0) && (WriteRegM == RsD || WriteRegM == RtD);
    assign lw_stall = MemtoRegE && e_hits_d;

`ifdef HAZARD_BRANCH_FWD_EN
    assign ForwardAD    = (RsD != '0) && (RsD == WriteRegM) && RegWriteM;
    assign ForwardBD    = (RtD != '0) && (RtD == WriteRegM) && RegWriteM;
    assign branch_stall = BranchD && ((RegWriteE && e_hits_d) || (MemtoRegM && m_hits_d));
`else
    // No comparator bypass: any pending M-stage write to a branch source must settle first.
    assign ForwardAD    = 1'b0;
    assign ForwardBD    = 1'b0;
    assign branch_stall = BranchD && ((RegWriteE && e_hits_d) || (MemtoRegM && m_hits_d)
                                      || (RegWriteM && m_hits_d));
`endif

    assign mem_stall = MemtoRegM && (mcnt_q != MCNT_LAST);
    assign sys_stall = (state_q == DRAIN) || (state_q == FIRE);

    always_comb begin
        state_d    = state_q;
        syscall_go = 1'b0;
        case (state_q)
            IDLE: begin
                if (syscallD && !lw_stall && !branch_stall && !mem_stall)
                    state_d = DRAIN;
            end
            DRAIN: begin
                if (!RegWriteE && !RegWriteM && !RegWriteW)
                    state_d = FIRE;
            end
            FIRE: begin
                syscall_go = !rst;
                state_d    = PASS;
            end
            PASS: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // A multi-cycle load freezes everything downstream of fetch and suppresses bubbles.
    always_comb begin
        StallF  = 1'b0;
        StallD  = 1'b0;
        StallEM = 1'b0;
        FlushE  = 1'b0;
        if (!rst) begin
            if (mem_stall) begin
                StallF  = 1'b1;
                StallD  = 1'b1;
                StallEM = 1'b1;
            end else begin
                StallF = lw_stall || branch_stall || sys_stall;
                StallD = StallF;
                FlushE = StallF;
            end
        end
    end

    always_comb begin
        mcnt_d        = mem_stall ? (mcnt_q + 2'd1) : 2'd0;
        stall_count_d = stall_count_q;
        if (StallF && stall_count_q != 16'hFFFF)
            stall_count_d = stall_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q       <= IDLE;
            mcnt_q        <= 2'd0;
            stall_count_q <= 16'd0;
        end else begin
            state_q       <= state_d;
            mcnt_q        <= mcnt_d;
            stall_count_q <= stall_count_d;
        end
    end

    assign stall_count = stall_count_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl (LOAD_LAT=3); branch expectations follow HAZARD_BRANCH_FWD_EN.
module tb_hazard_ctrl;

    logic       clk;
    logic       rst;
    logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
    logic       BranchD, syscallD, MemtoRegE, RegWriteE, MemtoRegM, RegWriteM, RegWriteW;
    logic       StallF, StallD, StallEM, FlushE, ForwardAD, ForwardBD, syscall_go;
    logic [1:0] ForwardAE, ForwardBE;
    logic [15:0] stall_count;

    int vectors = 0;
    int errors  = 0;

    hazard_ctrl #(.REG_W(5), .LOAD_LAT(3)) dut (
        .clk(clk), .rst(rst),
        .RsD(RsD), .RtD(RtD), .BranchD(BranchD), .syscallD(syscallD),
        .RsE(RsE), .RtE(RtE),
        .WriteRegE(WriteRegE), .MemtoRegE(MemtoRegE), .RegWriteE(RegWriteE),
        .WriteRegM(WriteRegM), .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM),
        .WriteRegW(WriteRegW), .RegWriteW(RegWriteW),
        .StallF(StallF), .StallD(StallD), .StallEM(StallEM), .FlushE(FlushE),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
        .syscall_go(syscall_go), .stall_count(stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        vectors++;
        assert (obs === exp) else begin
            errors++;
            $error("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        RsD = 0; RtD = 0; BranchD = 0; syscallD = 0;
        RsE = 0; RtE = 0;
        WriteRegE = 0; MemtoRegE = 0; RegWriteE = 0;
        WriteRegM = 0; MemtoRegM = 0; RegWriteM = 0;
        WriteRegW = 0; RegWriteW = 0;
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        tick();
        tick();
        check("rst_stall_count", stall_count, 16'd0);
        check("rst_StallF", {15'd0, StallF}, 16'd0);
        check("rst_syscall_go", {15'd0, syscall_go}, 16'd0);

        // load-use hazard held off while in reset
        MemtoRegE = 1; WriteRegE = 5; RtD = 5;
        settle();
        check("rst_gates_StallF", {15'd0, StallF}, 16'd0);
        check("rst_gates_FlushE", {15'd0, FlushE}, 16'd0);
        clear_inputs();
        tick();
        rst = 1'b0;
        settle();

        // forwarding
        RsE = 3; WriteRegM = 3; RegWriteM = 1; WriteRegW = 3; RegWriteW = 1;
        settle();
        check("fwdAE_M_priority", {14'd0, ForwardAE}, 16'd2);
        RsE = 0;
        settle();
        check("fwdAE_r0", {14'd0, ForwardAE}, 16'd0);
        RtE = 3; RegWriteM = 0;
        settle();
        check("fwdBE_W", {14'd0, ForwardBE}, 16'd1);
        RtE = 4;
        settle();
        check("fwdBE_none", {14'd0, ForwardBE}, 16'd0);
        clear_inputs();

        // load-use stall
        MemtoRegE = 1; WriteRegE = 5; RtD = 5;
        settle();
        check("lw_StallF", {15'd0, StallF}, 16'd1);
        check("lw_StallD", {15'd0, StallD}, 16'd1);
        check("lw_FlushE", {15'd0, FlushE}, 16'd1);
        check("lw_StallEM", {15'd0, StallEM}, 16'd0);
        tick();
        WriteRegE = 0; RtD = 0;
        settle();
        check("lw_r0_nostall", {15'd0, StallF}, 16'd0);
        check("count_after_lw", stall_count, 16'd1);
        clear_inputs();

        // three-cycle load in M, with a load-use hazard present in the first cycle
        MemtoRegM = 1; MemtoRegE = 1; WriteRegE = 5; RtD = 5;
        settle();
        check("mem0_StallEM", {15'd0, StallEM}, 16'd1);
        check("mem0_StallF", {15'd0, StallF}, 16'd1);
        check("mem0_FlushE_suppressed", {15'd0, FlushE}, 16'd0);
        tick();
        MemtoRegE = 0; WriteRegE = 0; RtD = 0;
        settle();
        check("mem1_StallEM", {15'd0, StallEM}, 16'd1);
        check("mem1_FlushE", {15'd0, FlushE}, 16'd0);
        tick();
        check("mem2_StallEM", {15'd0, StallEM}, 16'd0);
        check("mem2_StallF", {15'd0, StallF}, 16'd0);
        check("mem2_FlushE", {15'd0, FlushE}, 16'd0);
        tick();
        MemtoRegM = 0;
        settle();
        check("count_after_mem", stall_count, 16'd3);

        // branch depending on an M-stage ALU result
        BranchD = 1; RegWriteM = 1; WriteRegM = 7; RsD = 7;
        settle();
`ifdef HAZARD_BRANCH_FWD_EN
        check("br_ForwardAD", {15'd0, ForwardAD}, 16'd1);
        check("br_StallF", {15'd0, StallF}, 16'd0);
`else
        check("br_ForwardAD", {15'd0, ForwardAD}, 16'd0);
        check("br_StallF", {15'd0, StallF}, 16'd1);
`endif
        clear_inputs();
        BranchD = 1; RegWriteE = 1; WriteRegE = 4; RtD = 4;
        settle();
        check("br_E_StallF", {15'd0, StallF}, 16'd1);
        check("br_E_FlushE", {15'd0, FlushE}, 16'd1);
        clear_inputs();
        settle();

        // syscall: drain two cycles, fire once, pass, idle
        syscallD = 1; RegWriteM = 1;
        settle();
        check("sys_idle_StallF", {15'd0, StallF}, 16'd0);
        tick();
        check("sys_drain1_StallF", {15'd0, StallF}, 16'd1);
        check("sys_drain1_go", {15'd0, syscall_go}, 16'd0);
        tick();
        RegWriteM = 0;
        settle();
        check("sys_drain2_FlushE", {15'd0, FlushE}, 16'd1);
        check("sys_drain2_go", {15'd0, syscall_go}, 16'd0);
        tick();
        check("sys_fire_go", {15'd0, syscall_go}, 16'd1);
        check("sys_fire_StallF", {15'd0, StallF}, 16'd1);
        tick();
        check("sys_pass_go", {15'd0, syscall_go}, 16'd0);
        check("sys_pass_StallF", {15'd0, StallF}, 16'd0);
        tick();
        check("sys_idle2_StallF", {15'd0, StallF}, 16'd0);
        syscallD = 0;
        settle();
        check("count_after_sys", stall_count, 16'd6);
        tick();

        // reset in the middle of a drain
        syscallD = 1; RegWriteM = 1;
        tick();
        check("rstdrain_StallF", {15'd0, StallF}, 16'd1);
        rst = 1'b1;
        settle();
        check("rstdrain_gated", {15'd0, StallF}, 16'd0);
        tick();
        rst = 1'b0;
        syscallD = 0; RegWriteM = 0;
        settle();
        check("rstdrain_idle_StallF", {15'd0, StallF}, 16'd0);
        check("rstdrain_count", stall_count, 16'd0);

        // reset in the middle of a load restarts the latency count
        MemtoRegM = 1;
        settle();
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        settle();
        check("rstload_c0", {15'd0, StallEM}, 16'd1);
        tick();
        check("rstload_c1", {15'd0, StallEM}, 16'd1);
        tick();
        check("rstload_c2", {15'd0, StallEM}, 16'd0);
        MemtoRegM = 0;
        tick();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
